// File: rtl/encoder.sv
// encoder: registered one-hot-to-binary encoder, the inverse of the data-path decoder.
//
// A word sampled on an enabled edge is captured in stage 1, encoded and registered in
// stage 2, and presented on the output registers, so a word sampled at edge N is visible
// with valid_out=1 after edge N+2. Malformed words (zero or multi-hot) are flagged with
// error, and a saturating counter tallies them for debug readout.
//
// Parameters:
//   width     - number of index bits; the input word is 2**width bits wide
//   CNT_W     - width of the saturating error counter
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-high reset; overrides enable
//   enable    - sample in on this edge
//   in        - one-hot word to encode (2**width bits)
//   valid_out - high for one cycle per encoded word
//   out       - encoded index (highest set bit wins); holds during bubbles
//   error     - qualifies out; sampled word was not exactly one-hot; holds during bubbles
//   err_count - number of erroneous words seen, saturating at 2**CNT_W-1
module encoder #(
    parameter int unsigned width = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2**width-1:0]   in,
    output logic                  valid_out,
    output logic [width-1:0]      out,
    output logic                  error,
    output logic [CNT_W-1:0]      err_count
);

    localparam int unsigned NumBits = 2**width;
    localparam int unsigned PopW    = width + 1;

    // Stage 1: captured input word.
    logic [NumBits-1:0] s1_word_q;
    logic               s1_valid_q;

    // Stage 2: registered encode result.
    logic [width-1:0]   s2_idx_q;
    logic               s2_err_q;
    logic               s2_valid_q;

    // Output stage.
    logic [width-1:0]   out_q;
    logic               error_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;

    // Combinational encode of the stage-1 word.
    logic [width-1:0]   enc_idx;
    logic [PopW-1:0]    enc_pop;
    logic               enc_err;

    // Ascending scan: a later (higher) set bit overwrites the index, giving high priority.
    always_comb begin
        enc_idx = '0;
        enc_pop = '0;
        for (int unsigned i = 0; i < NumBits; i++) begin
            if (s1_word_q[i]) begin
                enc_idx = width'(i);
                enc_pop = enc_pop + PopW'(1);
            end
        end
        enc_err = (enc_pop != PopW'(1));
    end

    // Stage 1: capture on enabled edges; the word holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_word_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= enable;
            if (enable) begin
                s1_word_q <= in;
            end
        end
    end

    // Stage 2: register the encode result only for valid words.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_idx_q   <= '0;
            s2_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_idx_q <= enc_idx;
                s2_err_q <= enc_err;
            end
        end
    end

    // Output stage: out/error hold their last values across bubbles; the counter
    // advances on the same edge that presents an erroneous valid word.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_q   <= s2_idx_q;
                error_q <= s2_err_q;
                if (s2_err_q && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign valid_out = valid_q;
    assign out       = out_q;
    assign error     = error_q;
    assign err_count = cnt_q;

endmodule
